instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/rv_fetch_pkg.sv | 15 +
 rtl/fetch_timeout_ctr.sv | 28 ++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: FSM state encoding,
// the default reset PC and the canonical NOP encoding.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response-wait watchdog: counts consecutive cycles with run_i high and
// flags expiry on the LIMIT-th such cycle. Used only with FETCH_TIMEOUT_EN.
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  assign expired_o = run_i && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!run_i || expired_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect and a one-entry
// holding register. Optional response timeout enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  input  logic        mem_valid,
  input  logic [31:0] mem_data_out,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [11:0] mem_address,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_err
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         instr_valid_q;

  assign mem_request = (state_q == S_REQ);
  assign mem_we_re   = 1'b0;
  assign mem_mask    = '1;
  assign mem_address = fetch_pc_q[13:2];
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef FETCH_TIMEOUT_EN
  logic timeout_run;
  logic timeout_hit;
  logic fetch_err_q;

  assign timeout_run = (state_q == S_WAIT) && !mem_valid;
  assign fetch_err   = fetch_err_q;

  fetch_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .run_i    (timeout_run),
    .expired_o(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign fetch_err          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err_q   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Redirect flushes whatever is in flight or held, including a
      // response landing in the same cycle.
      state_q       <= S_REQ;
      fetch_pc_q    <= redirect_pc & ~32'h3;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ:  state_q <= S_WAIT;
        S_WAIT: begin
          if (mem_valid) begin
            instr_q       <= mem_data_out;
            instr_pc_q    <= fetch_pc_q;
            fetch_pc_q    <= fetch_pc_q + 32'd4;
            instr_valid_q <= 1'b1;
            state_q       <= S_FULL;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (timeout_hit) begin
            fetch_err_q <= 1'b1;
            state_q     <= S_REQ;
          end
`endif
        end
        S_FULL: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a per-instruction
// reference model; timeout scenario follows FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int unsigned TB_TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data_out = '0;
  logic        mem_request;
  logic        mem_we_re;
  logic [3:0]  mem_mask;
  logic [11:0] mem_address;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: next expected fetch address plus the held instruction.
  logic [31:0] exp_pc = TB_RESET_PC;
  logic        held_valid = 1'b0;
  logic [31:0] held_instr = '0;
  logic [31:0] held_pc = '0;
  logic [19:0] salt = '0;
  int          cap_cyc[$];
  logic [31:0] cap_pc[$];
  logic [11:0] req_addr[$];

  // Memory responder state
  logic        mem_en = 1'b1;
  logic        stray = 1'b0;
  logic        last_req = 1'b0;
  logic [11:0] last_addr = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC      (TB_RESET_PC),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_ready   (instr_ready),
    .mem_valid     (mem_valid),
    .mem_data_out  (mem_data_out),
    .mem_request   (mem_request),
    .mem_we_re     (mem_we_re),
    .mem_mask      (mem_mask),
    .mem_address   (mem_address),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_err     (fetch_err)
  );

  function automatic logic [31:0] mdata(input logic [11:0] a);
    return {salt, a};
  endfunction

  // Memory answers exactly one cycle after a request is seen.
  initial forever begin
    @(negedge clk);
    mem_valid    = stray || (mem_en && last_req);
    mem_data_out = stray ? 32'hDEAD_BEEF : mdata(last_addr);
    last_req     = mem_request;
    last_addr    = mem_address;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    exp_pc     = TB_RESET_PC;
    held_valid = 1'b0;
  endtask

  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic have;
    tick();
    have = held_valid;
    if (mem_request === 1'b1) begin
      req_addr.push_back(mem_address);
      total++;
      if (mem_address !== exp_pc[13:2] || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL req_addr: got addr=%h valid=%b, expected addr=%h valid=0",
                 mem_address, instr_valid, exp_pc[13:2]);
      end
    end
    if (held_valid) begin
      total++;
      if (instr_valid !== 1'b1 || instr !== held_instr || instr_pc !== held_pc) begin
        bad++;
        $display("FAIL hold: got v=%b instr=%h pc=%h, expected v=1 instr=%h pc=%h",
                 instr_valid, instr, instr_pc, held_instr, held_pc);
      end
    end else if (instr_valid === 1'b1) begin
      total++;
      if (instr_pc !== exp_pc || instr !== mdata(exp_pc[13:2])) begin
        bad++;
        $display("FAIL capture: got instr=%h pc=%h, expected instr=%h pc=%h",
                 instr, instr_pc, mdata(exp_pc[13:2]), exp_pc);
      end
      held_instr = mdata(exp_pc[13:2]);
      held_pc    = exp_pc;
      cap_cyc.push_back(cyc);
      cap_pc.push_back(exp_pc);
      exp_pc     = exp_pc + 32'd4;
      have       = 1'b1;
    end
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (redir) begin
      exp_pc     = rpc & ~32'h3;
      held_valid = 1'b0;
    end else begin
      held_valid = have && !rdy;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
          fetch_err !== 1'b0 || mem_request !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got v=%b instr=%h pc=%h err=%b req=%b, expected all 0",
                 instr_valid, instr, instr_pc, fetch_err, mem_request);
      end
      total++;
      if (mem_we_re !== 1'b0 || mem_mask !== 4'hF) begin
        bad++;
        $display("FAIL const_outputs: got we=%b mask=%h, expected we=0 mask=f", mem_we_re, mem_mask);
      end
    end
  endtask

  task automatic test_sequential();
    cap_cyc.delete(); cap_pc.delete(); req_addr.delete();
    model_reset();
    instr_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
    total++;
    if (req_addr.size() < 3 || cap_pc.size() < 3) begin
      bad++;
      $display("FAIL seq_count: got reqs=%0d caps=%0d, expected >=3 each", req_addr.size(), cap_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (req_addr[i] !== 12'(i) || cap_pc[i] !== 32'(4 * i)) begin
          bad++;
          $display("FAIL seq_order: idx %0d got addr=%h pc=%h, expected addr=%h pc=%h",
                   i, req_addr[i], cap_pc[i], 12'(i), 32'(4 * i));
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (cap_cyc[i] - cap_cyc[i-1] != 3) begin
          bad++;
          $display("FAIL throughput: got gap=%0d cycles, expected 3", cap_cyc[i] - cap_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int          guard;
    int          reqs;
    logic [31:0] snap_pc;
    guard = 0;
    do begin
      step(1'b0, 1'b0, '0);
      guard++;
    end while (instr_valid !== 1'b1 && guard < 12);
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_reach: got valid=%b after %0d cycles, expected 1", instr_valid, guard);
    end
    snap_pc = held_pc;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0);
      if (mem_request === 1'b1) reqs++;
    end
    total++;
    if (reqs != 0 || instr_pc !== snap_pc) begin
      bad++;
      $display("FAIL stall_hold: got reqs=%0d pc=%h, expected reqs=0 pc=%h", reqs, instr_pc, snap_pc);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic test_redirect_drop();
    int guard;
    guard = 0;
    do begin
      step(1'b1, 1'b0, '0);
      guard++;
    end while (mem_request !== 1'b1 && guard < 12);
    // Next cycle is the wait cycle where the response arrives.
    step(1'b1, 1'b1, 32'h0000_0103);
    step(1'b1, 1'b0, '0);
    total++;
    if (mem_request !== 1'b1 || mem_address !== 12'h040 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL redirect_drop: got req=%b addr=%h valid=%b, expected req=1 addr=040 valid=0",
               mem_request, mem_address, instr_valid);
    end
    cap_pc.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    total++;
    if (cap_pc.size() == 0 || cap_pc[0] !== 32'h0000_0100) begin
      bad++;
      $display("FAIL redirect_target: got caps=%0d first=%h, expected first=00000100",
               cap_pc.size(), (cap_pc.size() != 0) ? cap_pc[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    cap_pc.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    total++;
    if (cap_pc.size() < 2 || cap_pc[0] !== 32'hFFFF_FFFC || cap_pc[1] !== 32'h0) begin
      bad++;
      $display("FAIL wrap: got caps=%0d, expected FFFFFFFC then 00000000 (first=%h)",
               cap_pc.size(), (cap_pc.size() != 0) ? cap_pc[0] : 32'hx);
    end
  endtask

  task automatic test_timeout();
    int          guard;
    logic [11:0] addr0;
    guard = 0;
    do begin
      step(1'b1, 1'b0, '0);
      guard++;
    end while (mem_request !== 1'b1 && guard < 12);
    addr0 = exp_pc[13:2];
    mem_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i <= int'(TB_TIMEOUT); i++) begin
      tick();
      total++;
      if (mem_request !== 1'b0 || fetch_err !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait: wait cycle %0d got req=%b err=%b, expected 0 0", i, mem_request, fetch_err);
      end
    end
    tick();
    total++;
    if (fetch_err !== 1'b1 || mem_request !== 1'b1 || mem_address !== addr0) begin
      bad++;
      $display("FAIL timeout_fire: got err=%b req=%b addr=%h, expected err=1 req=1 addr=%h",
               fetch_err, mem_request, mem_address, addr0);
    end
    mem_en = 1'b1;
    cap_pc.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    total++;
    if (cap_pc.size() == 0 || fetch_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got caps=%0d err=%b, expected caps>0 err=1", cap_pc.size(), fetch_err);
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (mem_request !== 1'b0 || fetch_err !== 1'b0 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait_forever: cycle %0d got req=%b err=%b v=%b, expected 0 0 0",
                 i, mem_request, fetch_err, instr_valid);
      end
    end
    mem_en = 1'b1;
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, '0);
    total++;
    if (mem_address !== 12'h080 || mem_request !== 1'b1 || addr0 === 12'h080) begin
      bad++;
      $display("FAIL wait_recover: got req=%b addr=%h, expected req=1 addr=080", mem_request, mem_address);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
`endif
  endtask

  task automatic test_reset_midfetch();
    int guard;
    guard = 0;
    do begin
      step(1'b1, 1'b0, '0);
      guard++;
    end while (mem_request !== 1'b1 && guard < 12);
    tick();
    rst    = 1'b1;
    stray  = 1'b1;
    mem_en = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || mem_request !== 1'b0 || instr !== 32'h0 ||
        instr_pc !== 32'h0 || fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got v=%b req=%b instr=%h pc=%h err=%b, expected all 0",
               instr_valid, mem_request, instr, instr_pc, fetch_err);
    end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (mem_request !== 1'b1 || mem_address !== TB_RESET_PC[13:2] || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_reissue: got req=%b addr=%h v=%b, expected req=1 addr=%h v=0",
               mem_request, mem_address, instr_valid, TB_RESET_PC[13:2]);
    end
    stray  = 1'b0;
    mem_en = 1'b1;
    cap_pc.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    total++;
    if (cap_pc.size() == 0 || cap_pc[0] !== TB_RESET_PC) begin
      bad++;
      $display("FAIL reset_first_pc: got caps=%0d, expected first pc=%h", cap_pc.size(), TB_RESET_PC);
    end
  endtask

  task automatic test_random();
    int          start_caps;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    start_caps = cap_pc.size();
    for (int i = 0; i < 300; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom();
      step(rdy, rd, rpc);
    end
    step(1'b1, 1'b0, '0);
    total++;
    if (cap_pc.size() - start_caps < 20) begin
      bad++;
      $display("FAIL random_progress: got %0d captures, expected at least 20", cap_pc.size() - start_caps);
    end
  endtask

  initial begin
    salt = 20'($urandom());
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_wrap();
    test_timeout();
    test_reset_midfetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
